// File: rtl/fir_frame_scheduler_pkg.sv
// Shared types and defaults for the FIR frame scheduler.
package fir_frame_scheduler_pkg;

  localparam int unsigned SAMPLE_W         = 8;
  localparam int unsigned FRAME_LEN_DEF    = 20;
  localparam int unsigned PRIME_FRAMES_DEF = 2;
  localparam int unsigned FIFO_DEPTH_DEF   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Counter width helper that never returns zero.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fir_frame_scheduler_sample_fifo.sv
// Input sample FIFO. DEPTH must be a power of two, at least 2.
// A push while full is accepted when a pop happens on the same edge.
module sample_fifo
  import fir_frame_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned WIDTH = SAMPLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = clog2_min1(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Storage write; when full with a pop, the slot being vacated is reused.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers with wrap bit for full/empty discrimination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_frame_scheduler.sv
// Frame scheduler for a multi-cycle FIR datapath: feeds one sample per
// frame, primes the delay line, and captures one filtered result per frame.
module fir_frame_scheduler
  import fir_frame_scheduler_pkg::*;
#(
  parameter int unsigned FRAME_LEN    = FRAME_LEN_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned PRIME_FRAMES = PRIME_FRAMES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic signed [SAMPLE_W-1:0] m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic signed [SAMPLE_W-1:0] fir_in,
  output logic                       fir_ready,
  input  logic signed [SAMPLE_W-1:0] fir_result,
  output logic                       underrun,
  output logic                       out_drop,
  input  logic                       clr_flags
);

  localparam int unsigned CW = clog2_min1(FRAME_LEN);
  localparam int unsigned PW = clog2_min1(PRIME_FRAMES + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] PRIME_LAST = PW'(PRIME_FRAMES - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [PW-1:0] prime_cnt;
  logic [PW-1:0] prime_nx;

  logic          active;
  logic          wrap;
  logic          capture;
  logic          run_capture;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  sample_t       fifo_head;

  assign active      = (state != ST_IDLE);
  assign wrap        = active && (cnt == CNT_LAST);
  assign capture     = active && (cnt == '0);
  assign run_capture = capture && (state == ST_RUN);

  assign fifo_pop  = wrap && !fifo_empty;
  assign s_ready   = !fifo_full || fifo_pop;
  assign fifo_push = s_valid && s_ready;

  assign fir_ready = active;
  assign fir_in    = fifo_pop ? fifo_head : '0;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State, frame counter and prime counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      prime_cnt <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      prime_cnt <= prime_nx;
    end
  end

  // Next-state: stopping waits for the wrap cycle so a frame is never cut short.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    prime_nx = prime_cnt;
    case (state)
      ST_IDLE: begin
        cnt_nx   = '0;
        prime_nx = '0;
        if (en) begin
          state_nx = (PRIME_FRAMES == 0) ? ST_RUN : ST_PRIME;
        end
      end
      ST_PRIME, ST_RUN: begin
        cnt_nx = wrap ? '0 : cnt + 1'b1;
        if ((state == ST_PRIME) && capture) begin
          prime_nx = prime_cnt + 1'b1;
          if (prime_cnt == PRIME_LAST) begin
            state_nx = ST_RUN;
          end
        end
        if (wrap && !en) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output register: each RUN capture overwrites, acceptance clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (run_capture) begin
      m_data  <= fir_result;
      m_valid <= 1'b1;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Sticky flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun <= 1'b0;
      out_drop <= 1'b0;
    end else begin
      if (wrap && fifo_empty) underrun <= 1'b1;
      else if (clr_flags)     underrun <= 1'b0;
      if (run_capture && m_valid && !m_ready) out_drop <= 1'b1;
      else if (clr_flags)                     out_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_frame_scheduler.sv
// Directed bench for fir_frame_scheduler with hand-computed expectations.
module tb_fir_frame_scheduler;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic signed [7:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic signed [7:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic signed [7:0] fir_in;
  logic              fir_ready;
  logic signed [7:0] fir_result;
  logic              underrun;
  logic              out_drop;
  logic              clr_flags;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  fir_frame_scheduler #(
    .FRAME_LEN    (20),
    .FIFO_DEPTH   (4),
    .PRIME_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fir_in     (fir_in),
    .fir_ready  (fir_ready),
    .fir_result (fir_result),
    .underrun   (underrun),
    .out_drop   (out_drop),
    .clr_flags  (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%02h exp=%02h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_in;
    logic [7:0] tail_vals [4];
    rst_n = 1'b0; en = 1'b0; s_data = '0; s_valid = 1'b0;
    m_ready = 1'b0; fir_result = '0; clr_flags = 1'b0;
    #12;
    check("rst_s_ready", s_ready, 8'd1);
    check("rst_fir_ready", fir_ready, 8'd0);
    check("rst_m_valid", m_valid, 8'd0);
    check("rst_underrun", underrun, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Queue 10,20,30 while idle.
    s_valid = 1'b1; s_data = 8'sd10; step();
    s_data = 8'sd20; step();
    s_data = 8'sd30; step();
    s_valid = 1'b0;
    check("idle_fir_in", fir_in, 8'd0);
    check("idle_fir_ready", fir_ready, 8'd0);
    check("idle_s_ready", s_ready, 8'd1);

    // Start: cycle 0 is the first PRIME cycle.
    fir_result = 8'sh55;
    en = 1'b1;
    step(); cyc = 0;
    for (int c = 0; c < 60; c++) begin
      goto_cyc(c);
      exp_in = (c == 19) ? 8'd10 : (c == 39) ? 8'd20 : (c == 59) ? 8'd30 : 8'd0;
      check("frame_fir_in", fir_in, exp_in);
      check("frame_fir_ready", fir_ready, 8'd1);
      check("prime_m_valid", m_valid, (c > 40) ? 8'd1 : 8'd0);
    end
    goto_cyc(60);
    check("first_m_data", m_data, 8'h55);
    check("no_underrun", underrun, 8'd0);

    // Starved wrap at cycle 79.
    goto_cyc(79);
    check("starve_fir_in", fir_in, 8'd0);
    check("starve_pre_underrun", underrun, 8'd0);
    step();
    check("starve_underrun", underrun, 8'd1);
    step();
    clr_flags = 1'b1; m_ready = 1'b1; fir_result = 8'sh11;
    step();
    clr_flags = 1'b0; m_ready = 1'b0;
    check("clr_underrun", underrun, 8'd0);
    check("clr_out_drop", out_drop, 8'd0);
    check("accept_m_valid", m_valid, 8'd0);

    // Two captures without acceptance: 0x11 at 100, 0x22 at 120.
    goto_cyc(101);
    check("cap1_m_data", m_data, 8'h11);
    check("cap1_m_valid", m_valid, 8'd1);
    check("cap1_out_drop", out_drop, 8'd0);
    fir_result = 8'sh22;
    goto_cyc(121);
    check("cap2_m_data", m_data, 8'h22);
    check("cap2_m_valid", m_valid, 8'd1);
    check("cap2_out_drop", out_drop, 8'd1);
    m_ready = 1'b1;
    step();
    check("drain_m_valid", m_valid, 8'd0);
    m_ready = 1'b0;

    // Asynchronous reset at cnt=7 of frame 7.
    goto_cyc(147);
    check("pre_rst_m_valid", m_valid, 8'd1);
    check("pre_rst_fir_ready", fir_ready, 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_fir_ready", fir_ready, 8'd0);
    check("arst_fir_in", fir_in, 8'd0);
    check("arst_m_valid", m_valid, 8'd0);
    check("arst_m_data", m_data, 8'd0);
    check("arst_underrun", underrun, 8'd0);
    check("arst_out_drop", out_drop, 8'd0);
    check("arst_s_ready", s_ready, 8'd1);
    #3 rst_n = 1'b1;
    step(); cyc = 0;
    check("restart_fir_ready", fir_ready, 8'd1);
    goto_cyc(19);
    check("restart_wrap_fir_in", fir_in, 8'd0);
    check("restart_pre_underrun", underrun, 8'd0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("set_over_clr", underrun, 8'd1);

    // Stop request mid-frame: frame completes, then idle.
    en = 1'b0;
    goto_cyc(39);
    check("stop_still_active", fir_ready, 8'd1);
    step();
    check("stop_idle", fir_ready, 8'd0);

    // Fill: four pushes accepted, fifth refused.
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      check("fill_s_ready", s_ready, (i <= 4) ? 8'd1 : 8'd0);
      step();
    end
    s_valid = 1'b0;

    // Push on the wrap edge while full keeps the FIFO full.
    en = 1'b1;
    step(); cyc = 0;
    goto_cyc(18);
    check("full_s_ready", s_ready, 8'd0);
    step();
    check("full_wrap_fir_in", fir_in, 8'd1);
    check("full_wrap_s_ready", s_ready, 8'd1);
    s_valid = 1'b1; s_data = 8'sd6;
    step();
    s_valid = 1'b0;
    check("full_after_wrap", s_ready, 8'd0);
    tail_vals[0] = 8'd2; tail_vals[1] = 8'd3; tail_vals[2] = 8'd4; tail_vals[3] = 8'd6;
    for (int k = 1; k <= 4; k++) begin
      goto_cyc(20 * k + 19);
      check("drain_fir_in", fir_in, tail_vals[k-1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
